// File: rtl/tdm_demux_pkg.sv
// Shared types and default sizing for the TDM receive demultiplexer.
package tdm_pkg;

  typedef enum logic {
    TDM_IDLE = 1'b0,
    TDM_RUN  = 1'b1
  } tdm_state_e;

  localparam int unsigned TDM_N_CH = 4;
  localparam int unsigned TDM_W    = 8;

endpackage

// File: rtl/tdm_demux_slot_decoder.sv
// Slot index to one-hot channel write enable; all zeros when not enabled.
module slot_decoder #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned SW   = 2
) (
  input  logic [SW-1:0]   slot,
  input  logic            en,
  output logic [N_CH-1:0] we
);

  always_comb begin
    we = '0;
    if (en) we = N_CH'(1) << slot;
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive side: routes serial slot words to per-channel output registers.
// Define TDM_DEMUX_FRAME_LATCH_EN to publish whole frames at once via a shadow bank.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned N_CH = TDM_N_CH,
  parameter int unsigned W    = TDM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic [N_CH*W-1:0] out_data,
  output logic [N_CH-1:0]   out_valid,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned   SW   = $clog2(N_CH);
  localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

  tdm_state_e      state, state_n;
  logic [SW-1:0]   slot, slot_n, wr_slot;
  logic            wr_en, done_n, err_n;
  logic [N_CH-1:0] we;

  always_comb begin
    state_n = state;
    slot_n  = slot;
    wr_en   = 1'b0;
    wr_slot = slot;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      TDM_IDLE: begin
        if (in_valid) begin
          if (in_sof) begin
            wr_en   = 1'b1;
            wr_slot = '0;
            slot_n  = SW'(1);
            state_n = TDM_RUN;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      TDM_RUN: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (in_sof) begin
            // Early SOF restarts the frame in place without leaving RUN.
            err_n   = 1'b1;
            wr_slot = '0;
            slot_n  = SW'(1);
          end else if (slot == LAST) begin
            done_n  = 1'b1;
            slot_n  = '0;
            state_n = TDM_IDLE;
          end else begin
            slot_n = slot + SW'(1);
          end
        end
      end
      default: state_n = TDM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TDM_IDLE;
      slot  <= '0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
    end
  end

  slot_decoder #(
    .N_CH (N_CH),
    .SW   (SW)
  ) u_slot_decoder (
    .slot (wr_slot),
    .en   (wr_en),
    .we   (we)
  );

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  logic [N_CH*W-1:0] shadow;

  // The last slot bypasses the shadow so the whole frame lands in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      out_data   <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= done_n;
      frame_err  <= err_n;
      out_valid  <= {N_CH{done_n}};
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (we[k]) shadow[k*W +: W] <= in_data;
        if (done_n) out_data[k*W +: W] <= we[k] ? in_data : shadow[k*W +: W];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= done_n;
      frame_err  <= err_n;
      out_valid  <= we;
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (we[k]) out_data[k*W +: W] <= in_data;
      end
    end
  end
`endif

endmodule
